uart_tx_sched: RTL and testbench



---
 rtl/uart_tx_sched.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
//
// Shares the iodev UART transmitter between the CPU data port and NUM_REQ
// hardware byte sources (debug logger, trace unit, ...).
//
// The CPU always wins. Whenever cpu_en is high the iodev port is a plain wire
// from the CPU and the scheduler freezes. In every other cycle the scheduler
// owns the iodev port. It picks one requester round-robin, polls the UART
// status register (offset 0x3) until the busy bit clears, and then writes the
// latched byte to the UART data register (offset 0x2).
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   cpu_en               CPU selects iodev; overrides the scheduler
//   cpu_write_enable     CPU write strobes (bit 2 = word write)
//   cpu_addr             CPU address
//   cpu_data_in          CPU write data
//   cpu_data_out         read data returned to the CPU (= io_data_out)
//   req_valid[i]         requester i has a byte pending
//   req_data[8i+7:8i]    byte offered by requester i
//   req_ready[i]         one-hot; the byte is taken on the edge with valid&ready
//   io_en                iodev enable
//   io_write_enable      iodev write strobes
//   io_addr              iodev address
//   io_data_in           iodev write data
//   io_data_out          iodev read data (combinational)
//   sched_busy           scheduler is anywhere but IDLE
//   sent_count           bytes written by the scheduler, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module uart_tx_sched #(
   parameter int NUM_REQ = 2,
   parameter int CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   cpu_en,
   input  logic [2:0]             cpu_write_enable,
   input  logic [23:0]            cpu_addr,
   input  logic [31:0]            cpu_data_in,
   output logic [31:0]            cpu_data_out,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic                   io_en,
   output logic [2:0]             io_write_enable,
   output logic [23:0]            io_addr,
   output logic [31:0]            io_data_in,
   input  logic [31:0]            io_data_out,
   output logic                   sched_busy,
   output logic [CNT_W-1:0]       sent_count
);

   localparam int          IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [23:0] UART_DATA   = 24'h000002;
   localparam logic [23:0] UART_STATUS = 24'h000003;
   localparam logic [2:0]  WE_WORD     = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_POLL,
      ST_WRITE,
      ST_SETTLE
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   gnt_idx;
   logic [IDX_W-1:0]   gnt_inc;
   logic [7:0]         byte_q;

   logic               pick_vld;
   logic [IDX_W-1:0]   pick_idx;
   logic [IDX_W:0]     scan_sum;
   logic [IDX_W-1:0]   scan_idx;

   logic               grant_fire;
   logic               write_fire;

   logic [7:0]         req_byte [NUM_REQ];

   // Unpack the flat requester data bus into one byte per requester.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_byte[g] = req_data[8*g +: 8];
   end

   // Round-robin search: try rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ.
   // The sum is one bit wider so the wrap compare cannot overflow.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      scan_sum = '0;
      scan_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (scan_sum >= (IDX_W+1)'(NUM_REQ)) begin
            scan_sum = scan_sum - (IDX_W+1)'(NUM_REQ);
         end
         scan_idx = scan_sum[IDX_W-1:0];
         if (!pick_vld && req_valid[scan_idx]) begin
            pick_vld = 1'b1;
            pick_idx = scan_idx;
         end
      end
   end

   // After serving gnt_idx, the next requester up gets first look.
   assign gnt_inc = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

   // The scheduler only acts in cycles where the CPU leaves the bus alone.
   assign grant_fire = !cpu_en && (state == ST_IDLE) && pick_vld;
   assign write_fire = !cpu_en && (state == ST_WRITE);

   // Next state. A CPU access freezes the scheduler, except that a WRITE it
   // pre-empts falls back to POLL: the UART may have gone busy under the CPU,
   // so the status has to be read again before retrying the byte.
   always_comb begin
      state_nxt = state;
      if (cpu_en) begin
         if (state == ST_WRITE) begin
            state_nxt = ST_POLL;
         end
      end else begin
         case (state)
            ST_IDLE:   if (pick_vld)        state_nxt = ST_POLL;
            ST_POLL:   if (!io_data_out[0]) state_nxt = ST_WRITE;
            ST_WRITE:  state_nxt = ST_SETTLE;
            ST_SETTLE: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
         endcase
      end
   end

   // Bus mux and handshake. Fields the scheduler does not use are driven 0.
   // SETTLE leaves the bus idle for the cycle in which the UART raises busy,
   // so the next POLL cannot see a stale "not busy".
   always_comb begin
      io_en           = 1'b0;
      io_write_enable = '0;
      io_addr         = '0;
      io_data_in      = '0;
      req_ready       = '0;
      if (cpu_en) begin
         io_en           = 1'b1;
         io_write_enable = cpu_write_enable;
         io_addr         = cpu_addr;
         io_data_in      = cpu_data_in;
      end else begin
         case (state)
            ST_POLL: begin
               io_en   = 1'b1;
               io_addr = UART_STATUS;
            end
            ST_WRITE: begin
               io_en              = 1'b1;
               io_write_enable    = WE_WORD;
               io_addr            = UART_DATA;
               io_data_in         = {24'b0, byte_q};
               req_ready[gnt_idx] = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign cpu_data_out = io_data_out;
   assign sched_busy   = (state != ST_IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Grant, latched byte, fairness pointer and statistics. The byte is
   // latched at grant time so the requester may drop valid afterwards. A
   // reset discards it without a handshake.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rr_ptr     <= '0;
         gnt_idx    <= '0;
         byte_q     <= '0;
         sent_count <= '0;
      end else begin
         if (grant_fire) begin
            gnt_idx <= pick_idx;
            byte_q  <= req_byte[pick_idx];
         end
         if (write_fire) begin
            sent_count <= sent_count + CNT_W'(1);
            rr_ptr     <= gnt_inc;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

   localparam int NUM_REQ = 2;
   localparam int CNT_W   = 4;

   logic                 clk = 1'b0;
   logic                 resetn;
   logic                 cpu_en;
   logic [2:0]           cpu_write_enable;
   logic [23:0]          cpu_addr;
   logic [31:0]          cpu_data_in;
   logic [31:0]          cpu_data_out;
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 io_en;
   logic [2:0]           io_write_enable;
   logic [23:0]          io_addr;
   logic [31:0]          io_data_in;
   logic [31:0]          io_data_out;
   logic                 sched_busy;
   logic [CNT_W-1:0]     sent_count;

   always #5 clk = ~clk;

   uart_tx_sched #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .resetn           (resetn),
      .cpu_en           (cpu_en),
      .cpu_write_enable (cpu_write_enable),
      .cpu_addr         (cpu_addr),
      .cpu_data_in      (cpu_data_in),
      .cpu_data_out     (cpu_data_out),
      .req_valid        (req_valid),
      .req_data         (req_data),
      .req_ready        (req_ready),
      .io_en            (io_en),
      .io_write_enable  (io_write_enable),
      .io_addr          (io_addr),
      .io_data_in       (io_data_in),
      .io_data_out      (io_data_out),
      .sched_busy       (sched_busy),
      .sent_count       (sent_count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Requester byte queues (head is on the wire), UART write log, model.
   bit [7:0] q0[$];
   bit [7:0] q1[$];
   bit [7:0] wr_log[$];
   bit [7:0] exp_log[$];
   int       wr_cyc[$];
   int       busy_cnt      = 0;
   int       post_busy_max = 0;
   int       cyc           = 0;
   int       model_rr      = 0;
   int       model_cnt     = 0;

   // Values sampled mid-cycle by cycle().
   logic        s_io_en;
   logic [2:0]  s_we;
   logic [23:0] s_addr;
   logic [31:0] s_din;
   logic [1:0]  s_ready;
   logic        s_busy;
   logic [3:0]  s_cnt;
   logic        s_wr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_req();
      req_valid[0]   = (q0.size() != 0);
      req_valid[1]   = (q1.size() != 0);
      req_data[7:0]  = (q0.size() != 0) ? q0[0] : 8'($urandom);
      req_data[15:8] = (q1.size() != 0) ? q1[0] : 8'($urandom);
   endtask

   // One clock cycle, entered and left just after a falling edge.
   task automatic cycle();
      bit hs0;
      bit hs1;
      io_data_out    = $urandom;
      io_data_out[0] = (busy_cnt != 0);
      #1;
      s_io_en = io_en;
      s_we    = io_write_enable;
      s_addr  = io_addr;
      s_din   = io_data_in;
      s_ready = req_ready;
      s_busy  = sched_busy;
      s_cnt   = sent_count;
      s_wr    = !cpu_en && io_en && (io_write_enable == 3'b100) && (io_addr == 24'h000002);
      hs0     = req_valid[0] && req_ready[0];
      hs1     = req_valid[1] && req_ready[1];
      if (s_wr) begin
         wr_log.push_back(io_data_in[7:0]);
         wr_cyc.push_back(cyc);
      end
      chk("cpu_data_out", cpu_data_out, io_data_out);
      if (cpu_en) begin
         chk("cpu_mirror_en",    32'(io_en), 32'd1);
         chk("cpu_mirror_we",    32'(io_write_enable), 32'(cpu_write_enable));
         chk("cpu_mirror_addr",  32'(io_addr), 32'(cpu_addr));
         chk("cpu_mirror_data",  io_data_in, cpu_data_in);
         chk("cpu_mirror_ready", 32'(req_ready), 32'd0);
      end else begin
         chk("ready_iff_write", 32'(s_ready != 0), 32'(s_wr));
      end
      if (s_wr) chk("hs_onehot", 32'(hs0) + 32'(hs1), 32'd1);
      if (hs0)  chk("hs_data0", 32'(io_data_in[7:0]), 32'(q0[0]));
      if (hs1)  chk("hs_data1", 32'(io_data_in[7:0]), 32'(q1[0]));
      @(posedge clk);
      #1;
      cyc++;
      if (hs0) void'(q0.pop_front());
      if (hs1) void'(q1.pop_front());
      if (s_wr) busy_cnt = (post_busy_max > 0) ? int'($urandom_range(0, post_busy_max)) : 0;
      else if (busy_cnt > 0) busy_cnt--;
      @(negedge clk);
      drive_req();
   endtask

   // Reference: strict round-robin over the non-empty queues, starting at
   // model_rr, with every requester holding valid until its queue drains.
   task automatic build_expected();
      bit [7:0] a[$];
      bit [7:0] b[$];
      int       p;
      int       pick;
      a = q0;
      b = q1;
      p = model_rr;
      exp_log = {};
      while (a.size() + b.size() > 0) begin
         if (p == 0) pick = (a.size() != 0) ? 0 : 1;
         else        pick = (b.size() != 0) ? 1 : 0;
         if (pick == 0) exp_log.push_back(a.pop_front());
         else           exp_log.push_back(b.pop_front());
         p = 1 - pick;
         model_cnt = (model_cnt + 1) % (1 << CNT_W);
      end
      model_rr = p;
   endtask

   task automatic drain(input bit rnd_cpu, input int budget, input string tag);
      int n;
      n = 0;
      while ((q0.size() + q1.size() != 0 || sched_busy) && n < budget) begin
         if (rnd_cpu) begin
            cpu_en           = ($urandom_range(0, 4) == 0);
            cpu_write_enable = 3'($urandom);
            cpu_addr         = 24'($urandom);
            cpu_data_in      = $urandom;
         end
         cycle();
         n++;
      end
      cpu_en           = 1'b0;
      cpu_write_enable = '0;
      chk({tag, "_timeout"}, 32'(n < budget), 32'd1);
   endtask

   task automatic compare_log(input string tag);
      chk({tag, "_wr_count"}, 32'(wr_log.size()), 32'(exp_log.size()));
      for (int i = 0; i < wr_log.size() && i < exp_log.size(); i++) begin
         chk({tag, "_wr_byte"}, 32'(wr_log[i]), 32'(exp_log[i]));
      end
      chk({tag, "_sent_count"}, 32'(sent_count), 32'(model_cnt));
      wr_log = {};
      wr_cyc = {};
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      cycle();
      resetn    = 1'b1;
      model_rr  = 0;
      model_cnt = 0;
      busy_cnt  = 0;
      wr_log    = {};
      wr_cyc    = {};
      chk("rst_busy",  32'(sched_busy), 32'd0);
      chk("rst_count", 32'(sent_count), 32'd0);
      chk("rst_io_en", 32'(io_en), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, required finish before 500us");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int n0;
      resetn           = 1'b0;
      cpu_en           = 1'b0;
      cpu_write_enable = '0;
      cpu_addr         = '0;
      cpu_data_in      = '0;
      req_valid        = '0;
      req_data         = '0;
      io_data_out      = '0;
      @(negedge clk);
      cycle();
      do_reset();

      // Single byte on an idle UART.
      q0.push_back(8'h41);
      build_expected();
      drive_req();
      cycle();
      chk("t1_idle_io_en", 32'(s_io_en), 32'd0);
      chk("t1_idle_busy",  32'(s_busy), 32'd0);
      cycle();
      chk("t1_poll_en",    32'(s_io_en), 32'd1);
      chk("t1_poll_we",    32'(s_we), 32'd0);
      chk("t1_poll_addr",  32'(s_addr), 32'h3);
      chk("t1_poll_din",   s_din, 32'd0);
      chk("t1_poll_ready", 32'(s_ready), 32'd0);
      chk("t1_poll_busy",  32'(s_busy), 32'd1);
      cycle();
      chk("t1_wr_en",      32'(s_io_en), 32'd1);
      chk("t1_wr_we",      32'(s_we), 32'h4);
      chk("t1_wr_addr",    32'(s_addr), 32'h2);
      chk("t1_wr_din",     s_din, 32'h00000041);
      chk("t1_wr_ready",   32'(s_ready), 32'b01);
      chk("t1_wr_cnt",     32'(s_cnt), 32'd0);
      cycle();
      chk("t1_settle_en",  32'(s_io_en), 32'd0);
      chk("t1_settle_rdy", 32'(s_ready), 32'd0);
      chk("t1_settle_bsy", 32'(s_busy), 32'd1);
      chk("t1_settle_cnt", 32'(s_cnt), 32'd1);
      cycle();
      chk("t1_idle2_busy", 32'(s_busy), 32'd0);
      compare_log("t1");

      // Contention from reset: both valid, strict alternation, 4-cycle pitch.
      do_reset();
      q0.push_back(8'h10); q0.push_back(8'h10);
      q1.push_back(8'h20); q1.push_back(8'h20);
      build_expected();
      drive_req();
      t0 = cyc;
      drain(1'b0, 100, "cont");
      chk("cont_latency", 32'(wr_cyc.size() > 0 ? wr_cyc[0] - t0 : -1), 32'd2);
      for (int i = 1; i < wr_cyc.size(); i++) begin
         chk("cont_interval", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd4);
      end
      compare_log("cont");

      // UART busy for 50 polls, then the write in the cycle after it clears.
      q0.push_back(8'h55);
      build_expected();
      drive_req();
      busy_cnt = 51;
      cycle();
      for (int i = 0; i < 50; i++) begin
         cycle();
         chk("hold_addr",    32'(s_addr), 32'h3);
         chk("hold_nowrite", 32'(s_wr), 32'd0);
      end
      cycle();
      chk("hold_clear_poll", 32'(s_addr), 32'h3);
      cycle();
      chk("hold_write",    32'(s_wr), 32'd1);
      chk("hold_wr_data",  s_din, 32'h00000055);
      drain(1'b0, 20, "hold");
      compare_log("hold");

      // CPU takes the bus in the WRITE cycle; byte retried after a re-poll.
      q0.push_back(8'h77);
      build_expected();
      drive_req();
      cycle();
      cycle();
      cpu_en           = 1'b1;
      cpu_addr         = 24'h000000;
      cpu_write_enable = 3'b100;
      cpu_data_in      = 32'hCAFE0123;
      cycle();
      chk("cpu_int_nowrite", 32'(s_wr), 32'd0);
      chk("cpu_int_ready",   32'(s_ready), 32'd0);
      cpu_en           = 1'b0;
      cpu_write_enable = '0;
      cycle();
      chk("cpu_int_repoll_addr", 32'(s_addr), 32'h3);
      chk("cpu_int_repoll_we",   32'(s_we), 32'd0);
      cycle();
      chk("cpu_int_write", 32'(s_wr), 32'd1);
      chk("cpu_int_data",  s_din, 32'h00000077);
      drain(1'b0, 20, "cpu_int");
      compare_log("cpu_int");

      // Reset while polling with requester 1 granted; requester 0 goes first after.
      q0.push_back(8'h99);
      q1.push_back(8'hAA);
      drive_req();
      busy_cnt = 100;
      cycle();
      cycle();
      chk("rstpoll_in_poll", 32'(s_addr), 32'h3);
      resetn = 1'b0;
      cycle();
      chk("rstpoll_ready", 32'(s_ready), 32'd0);
      chk("rstpoll_nowr",  32'(s_wr), 32'd0);
      resetn = 1'b1;
      chk("rstpoll_busy",  32'(sched_busy), 32'd0);
      chk("rstpoll_cnt",   32'(sent_count), 32'd0);
      busy_cnt  = 0;
      model_rr  = 0;
      model_cnt = 0;
      wr_log    = {};
      wr_cyc    = {};
      build_expected();
      drain(1'b0, 50, "rstpoll");
      compare_log("rstpoll");

      // Randomized traffic with CPU intrusions and UART busy; 17 bytes wrap to 1.
      do_reset();
      post_busy_max = 5;
      busy_cnt = int'($urandom_range(0, 10));
      n0 = int'($urandom_range(0, 17));
      for (int i = 0; i < 17; i++) begin
         if (i < n0) q0.push_back(8'($urandom));
         else        q1.push_back(8'($urandom));
      end
      build_expected();
      drive_req();
      drain(1'b1, 3000, "wrap");
      chk("wrap_count", 32'(sent_count), 32'd1);
      compare_log("wrap");

      for (int r = 0; r < 3; r++) begin
         n0 = int'($urandom_range(0, 12));
         for (int i = 0; i < n0; i++) q0.push_back(8'($urandom));
         n0 = int'($urandom_range(0, 12));
         for (int i = 0; i < n0; i++) q1.push_back(8'($urandom));
         build_expected();
         drive_req();
         drain(1'b1, 3000, "rand");
         compare_log("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
